// File: rtl/mat_mul_pkg.sv
// Shared definitions for the mat_mul sequencer: default element sizes, the FSM
// state encoding and helpers that convert between flat buffer rows and element arrays.
package mat_mul_pkg;

  localparam int MM_W_IN  = 8;
  localparam int MM_W_OUT = 32;
  localparam int MM_N     = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    FIRE,
    WAIT,
    STORE
  } state_t;

  function automatic logic [MM_N-1:0][MM_W_IN-1:0] unpack_row(
    input logic [MM_N*MM_W_IN-1:0] row
  );
    logic [MM_N-1:0][MM_W_IN-1:0] elems;
    for (int j = 0; j < MM_N; j++) begin
      elems[j] = row[j*MM_W_IN +: MM_W_IN];
    end
    return elems;
  endfunction

  function automatic logic [MM_N*MM_W_OUT-1:0] pack_row(
    input logic [MM_N-1:0][MM_W_OUT-1:0] elems
  );
    logic [MM_N*MM_W_OUT-1:0] row;
    for (int j = 0; j < MM_N; j++) begin
      row[j*MM_W_OUT +: MM_W_OUT] = elems[j];
    end
    return row;
  endfunction

endpackage

// File: rtl/mat_mul_ctrl.sv
// Sequencer for the mat_mul datapath: loads both operands from the row buffer, fires
// one multiply, waits for the result (bounded by TIMEOUT) and writes it back row by row.
module mat_mul_ctrl
  import mat_mul_pkg::*;
#(
  parameter int W_IN    = MM_W_IN,
  parameter int W_OUT   = MM_W_OUT,
  parameter int N       = MM_N,
  parameter int AW      = 10,
  parameter int TIMEOUT = 64
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           start,
  input  logic [AW-1:0]                  base_a,
  input  logic [AW-1:0]                  base_b,
  input  logic [AW-1:0]                  base_c,
  output logic                           busy,
  output logic                           done,
  output logic                           error,
  output logic                           rd_en,
  output logic [AW-1:0]                  rd_addr,
  input  logic [N*W_IN-1:0]              rd_data,
  output logic                           wr_en,
  output logic [AW-1:0]                  wr_addr,
  output logic [N*W_OUT-1:0]             wr_data,
  output logic                           mm_cen,
  output logic                           mm_valid_in,
  output logic [N-1:0][N-1:0][W_IN-1:0]  mm_matrix_1,
  output logic [N-1:0][N-1:0][W_IN-1:0]  mm_matrix_2,
  input  logic                           mm_valid_out,
  input  logic [N-1:0][N-1:0][W_OUT-1:0] mm_result
);

  localparam int CNT_W = $clog2(N + 1);
  localparam int IDX_W = $clog2(N);
  localparam int TMO_W = $clog2(TIMEOUT);

  state_t                         r_state;
  state_t                         w_next_state;
  logic [CNT_W-1:0]               r_row_cnt;
  logic [CNT_W-1:0]               w_row_cnt_nxt;
  logic [TMO_W-1:0]               r_tmo_cnt;
  logic [TMO_W-1:0]               w_tmo_cnt_nxt;
  logic                           r_done;
  logic                           r_error;
  logic                           w_done_nxt;
  logic                           w_error_nxt;
  logic                           w_start_acc;
  logic                           w_snap_en;
  logic                           w_rd_en;
  logic [AW-1:0]                  w_rd_addr;
  logic                           w_wr_en;
  logic [AW-1:0]                  w_wr_addr;
  logic                           w_valid_in;
  logic [AW-1:0]                  r_base_a;
  logic [AW-1:0]                  r_base_b;
  logic [AW-1:0]                  r_base_c;
  logic                           r_cap_pend;
  logic                           r_cap_b;
  logic [IDX_W-1:0]               r_cap_row;
  logic [N-1:0][N-1:0][W_IN-1:0]  r_mat1;
  logic [N-1:0][N-1:0][W_IN-1:0]  r_mat2;
  logic [N-1:0][N-1:0][W_OUT-1:0] r_snap;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_row_cnt <= '0;
      r_tmo_cnt <= '0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_row_cnt <= w_row_cnt_nxt;
      r_tmo_cnt <= w_tmo_cnt_nxt;
      r_done    <= w_done_nxt;
      r_error   <= w_error_nxt;
    end
  end

  // LOAD_B runs one cycle past its last read so the final row lands before FIRE.
  always_comb begin
    w_next_state  = r_state;
    w_row_cnt_nxt = r_row_cnt;
    w_tmo_cnt_nxt = r_tmo_cnt;
    w_done_nxt    = 1'b0;
    w_error_nxt   = 1'b0;
    w_start_acc   = 1'b0;
    w_snap_en     = 1'b0;
    w_rd_en       = 1'b0;
    w_rd_addr     = '0;
    w_wr_en       = 1'b0;
    w_wr_addr     = '0;
    w_valid_in    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_start_acc   = 1'b1;
          w_row_cnt_nxt = '0;
          w_next_state  = LOAD_A;
        end
      end
      LOAD_A: begin
        w_rd_en   = 1'b1;
        w_rd_addr = r_base_a + AW'(r_row_cnt);
        if (r_row_cnt == CNT_W'(N - 1)) begin
          w_row_cnt_nxt = '0;
          w_next_state  = LOAD_B;
        end else begin
          w_row_cnt_nxt = r_row_cnt + 1'b1;
        end
      end
      LOAD_B: begin
        if (r_row_cnt == CNT_W'(N)) begin
          w_row_cnt_nxt = '0;
          w_next_state  = FIRE;
        end else begin
          w_rd_en       = 1'b1;
          w_rd_addr     = r_base_b + AW'(r_row_cnt);
          w_row_cnt_nxt = r_row_cnt + 1'b1;
        end
      end
      FIRE: begin
        w_valid_in    = 1'b1;
        w_tmo_cnt_nxt = '0;
        w_next_state  = WAIT;
      end
      WAIT: begin
        if (mm_valid_out) begin
          w_snap_en     = 1'b1;
          w_row_cnt_nxt = '0;
          w_next_state  = STORE;
        end else if (r_tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
          w_error_nxt  = 1'b1;
          w_next_state = IDLE;
        end else begin
          w_tmo_cnt_nxt = r_tmo_cnt + 1'b1;
        end
      end
      STORE: begin
        w_wr_en   = 1'b1;
        w_wr_addr = r_base_c + AW'(r_row_cnt);
        if (r_row_cnt == CNT_W'(N - 1)) begin
          w_row_cnt_nxt = '0;
          w_done_nxt    = 1'b1;
          w_next_state  = IDLE;
        end else begin
          w_row_cnt_nxt = r_row_cnt + 1'b1;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Read data arrives one cycle after its strobe, so the target row is remembered here.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_base_a   <= '0;
      r_base_b   <= '0;
      r_base_c   <= '0;
      r_cap_pend <= 1'b0;
      r_cap_b    <= 1'b0;
      r_cap_row  <= '0;
      r_mat1     <= '0;
      r_mat2     <= '0;
      r_snap     <= '0;
    end else begin
      if (w_start_acc) begin
        r_base_a <= base_a;
        r_base_b <= base_b;
        r_base_c <= base_c;
      end
      r_cap_pend <= w_rd_en;
      if (w_rd_en) begin
        r_cap_b   <= (r_state == LOAD_B);
        r_cap_row <= r_row_cnt[IDX_W-1:0];
      end
      if (r_cap_pend) begin
        if (r_cap_b) begin
          r_mat2[r_cap_row] <= unpack_row(rd_data);
        end else begin
          r_mat1[r_cap_row] <= unpack_row(rd_data);
        end
      end
      if (w_snap_en) begin
        r_snap <= mm_result;
      end
    end
  end

  assign busy        = (r_state != IDLE);
  assign mm_cen      = (r_state != IDLE);
  assign done        = r_done;
  assign error       = r_error;
  assign rd_en       = w_rd_en;
  assign rd_addr     = w_rd_addr;
  assign wr_en       = w_wr_en;
  assign wr_addr     = w_wr_addr;
  assign wr_data     = w_wr_en ? pack_row(r_snap[r_row_cnt[IDX_W-1:0]]) : '0;
  assign mm_valid_in = w_valid_in;
  assign mm_matrix_1 = r_mat1;
  assign mm_matrix_2 = r_mat2;

endmodule

// File: tb/tb_mat_mul_ctrl.sv
// Self-checking bench for mat_mul_ctrl: models the row buffer and the mat_mul datapath
// and checks sequencing, data routing, latency, timeout, address wrap and reset abort.
module tb_mat_mul_ctrl;

  localparam int N       = 8;
  localparam int W_IN    = 8;
  localparam int W_OUT   = 32;
  localparam int AW      = 10;
  localparam int TIMEOUT = 64;
  localparam int DEPTH   = 1 << AW;

  logic                           clk;
  logic                           rstn;
  logic                           start;
  logic [AW-1:0]                  base_a;
  logic [AW-1:0]                  base_b;
  logic [AW-1:0]                  base_c;
  logic                           busy;
  logic                           done;
  logic                           error;
  logic                           rd_en;
  logic [AW-1:0]                  rd_addr;
  logic [N*W_IN-1:0]              rd_data;
  logic                           wr_en;
  logic [AW-1:0]                  wr_addr;
  logic [N*W_OUT-1:0]             wr_data;
  logic                           mm_cen;
  logic                           mm_valid_in;
  logic [N-1:0][N-1:0][W_IN-1:0]  mm_matrix_1;
  logic [N-1:0][N-1:0][W_IN-1:0]  mm_matrix_2;
  logic                           mm_valid_out;
  logic [N-1:0][N-1:0][W_OUT-1:0] mm_result;

  mat_mul_ctrl #(
    .W_IN(W_IN), .W_OUT(W_OUT), .N(N), .AW(AW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .base_a(base_a), .base_b(base_b), .base_c(base_c),
    .busy(busy), .done(done), .error(error),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .mm_cen(mm_cen), .mm_valid_in(mm_valid_in),
    .mm_matrix_1(mm_matrix_1), .mm_matrix_2(mm_matrix_2),
    .mm_valid_out(mm_valid_out), .mm_result(mm_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int                matA [N][N];
  int                matB [N][N];
  logic [N*W_IN-1:0] mem  [DEPTH];

  int                             doneCnt, doneCyc, errCnt, errCyc;
  int                             busyCyc, cenCyc, vinCnt, fireCyc;
  int                             rdAddrQ [$];
  int                             wrAddrQ [$];
  logic [N*W_OUT-1:0]             wrDataQ [$];
  logic [N-1:0][N-1:0][W_IN-1:0]  seenM1, seenM2;
  bit                             rstApplied;
  logic [6:0]                     rstCtl;
  logic [N*W_OUT-1:0]             rstWr;
  bit                             rstMatNz;

  function automatic logic [N*W_IN-1:0] rndRow();
    logic [N*W_IN-1:0] row;
    for (int j = 0; j < N; j++) row[j*W_IN +: W_IN] = W_IN'($urandom());
    return row;
  endfunction

  function automatic logic [N-1:0][N-1:0][W_OUT-1:0] rndResult();
    logic [N-1:0][N-1:0][W_OUT-1:0] res;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) res[i][j] = W_OUT'($urandom());
    return res;
  endfunction

  // Behavioural mat_mul: plain signed matrix product of whatever operands it was handed.
  function automatic logic [N-1:0][N-1:0][W_OUT-1:0] mmModel(
    input logic [N-1:0][N-1:0][W_IN-1:0] m1,
    input logic [N-1:0][N-1:0][W_IN-1:0] m2
  );
    logic [N-1:0][N-1:0][W_OUT-1:0] res;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        int acc = 0;
        for (int k = 0; k < N; k++) acc += int'($signed(m1[i][k])) * int'($signed(m2[k][j]));
        res[i][j] = W_OUT'(acc);
      end
    return res;
  endfunction

  // One operation, cycle by cycle: cycle 0 carries the start pulse. lat < 0 means the
  // datapath never answers; rstAt >= 0 pulls reset once that many writes were seen.
  task automatic applyStimulus(input int ba, input int bb, input int bc, input int lat,
                               input int extraStartCyc, input int strayCyc, input int rstAt);
    logic                           pendRd;
    int                             pendAddr;
    int                             resCyc;
    int                             drain;
    logic [N-1:0][N-1:0][W_OUT-1:0] res;
    doneCnt = 0; doneCyc = -1; errCnt = 0; errCyc = -1;
    busyCyc = 0; cenCyc = 0; vinCnt = 0; fireCyc = -1;
    rdAddrQ.delete(); wrAddrQ.delete(); wrDataQ.delete();
    rstApplied = 0; rstCtl = '0; rstWr = '0; rstMatNz = 0;
    pendRd = 1'b0; pendAddr = 0; resCyc = -1; drain = -1; res = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk);
      #1;
      if (rstAt >= 0 && wrAddrQ.size() == rstAt) begin
        rstn = 1'b0;
        #1;
        rstApplied = 1;
        rstCtl     = {busy, done, error, rd_en, wr_en, mm_cen, mm_valid_in};
        rstWr      = wr_data;
        rstMatNz   = (mm_matrix_1 != '0) || (mm_matrix_2 != '0);
        break;
      end
      start = (cyc == 0) || (cyc == extraStartCyc);
      if (cyc == 0) begin
        base_a = AW'(ba); base_b = AW'(bb); base_c = AW'(bc);
      end else if (cyc == extraStartCyc) begin
        base_a = AW'(ba + 512); base_b = AW'(bb + 256); base_c = AW'(bc + 128);
      end
      rd_data      = pendRd ? mem[pendAddr] : rndRow();
      mm_valid_out = (cyc == resCyc) || (cyc == strayCyc);
      mm_result    = (cyc == resCyc) ? res : rndResult();
      if (busy) busyCyc++;
      if (mm_cen) cenCyc++;
      if (rd_en) rdAddrQ.push_back(int'(rd_addr));
      pendRd   = rd_en;
      pendAddr = int'(rd_addr);
      if (wr_en) begin
        wrAddrQ.push_back(int'(wr_addr));
        wrDataQ.push_back(wr_data);
      end
      if (mm_valid_in) begin
        vinCnt++;
        if (vinCnt == 1) begin
          fireCyc = cyc;
          seenM1  = mm_matrix_1;
          seenM2  = mm_matrix_2;
          res     = mmModel(mm_matrix_1, mm_matrix_2);
          if (lat >= 0) resCyc = cyc + 1 + lat;
        end
      end
      if (done) begin doneCnt++; doneCyc = cyc; end
      if (error) begin errCnt++; errCyc = cyc; end
      if ((done || error) && drain < 0) drain = 6;
      if (drain == 0) break;
      if (drain > 0) drain--;
    end
    start        = 1'b0;
    mm_valid_out = 1'b0;
  endtask

  task automatic loadMem(input int ba, input int bb);
    logic [N*W_IN-1:0] rowA, rowB;
    for (int r = 0; r < N; r++) begin
      for (int j = 0; j < N; j++) begin
        rowA[j*W_IN +: W_IN] = W_IN'(matA[r][j]);
        rowB[j*W_IN +: W_IN] = W_IN'(matB[r][j]);
      end
      mem[(ba + r) % DEPTH] = rowA;
      mem[(bb + r) % DEPTH] = rowB;
    end
  endtask

  task automatic randomMatrices();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        matA[i][j] = int'($urandom_range(0, 255)) - 128;
        matB[i][j] = int'($urandom_range(0, 255)) - 128;
      end
  endtask

  task automatic test_matrix_op(input string name, input int ba, input int bb, input int bc,
                                input int lat, input int extraStartCyc, input int strayCyc);
    logic [N*W_OUT-1:0] wd;
    logic [W_OUT-1:0]   expEl;
    bit                 ok;
    loadMem(ba, bb);
    applyStimulus(ba, bb, bc, lat, extraStartCyc, strayCyc, -1);
    checks++;
    if (doneCnt !== 1) begin
      failures++; $display("[TB] FAIL %s done_count: got %0d expected 1", name, doneCnt);
    end
    checks++;
    if (doneCyc !== 3*N + 4 + lat) begin
      failures++; $display("[TB] FAIL %s done_cycle: got %0d expected %0d", name, doneCyc, 3*N + 4 + lat);
    end
    checks++;
    if (errCnt !== 0) begin
      failures++; $display("[TB] FAIL %s error_count: got %0d expected 0", name, errCnt);
    end
    checks++;
    if (busyCyc !== 3*N + 3 + lat) begin
      failures++; $display("[TB] FAIL %s busy_cycles: got %0d expected %0d", name, busyCyc, 3*N + 3 + lat);
    end
    checks++;
    if (cenCyc !== 3*N + 3 + lat) begin
      failures++; $display("[TB] FAIL %s cen_cycles: got %0d expected %0d", name, cenCyc, 3*N + 3 + lat);
    end
    checks++;
    if (vinCnt !== 1 || fireCyc !== 2*N + 2) begin
      failures++; $display("[TB] FAIL %s valid_in: got count %0d at cycle %0d expected 1 at %0d",
                           name, vinCnt, fireCyc, 2*N + 2);
    end
    checks++;
    if (rdAddrQ.size() !== 2*N) begin
      failures++; $display("[TB] FAIL %s read_count: got %0d expected %0d", name, rdAddrQ.size(), 2*N);
    end
    for (int r = 0; r < 2*N && r < rdAddrQ.size(); r++) begin
      int expAddr = (r < N) ? (ba + r) % DEPTH : (bb + r - N) % DEPTH;
      checks++;
      if (rdAddrQ[r] !== expAddr) begin
        failures++; $display("[TB] FAIL %s rd_addr[%0d]: got %0d expected %0d", name, r, rdAddrQ[r], expAddr);
      end
    end
    ok = 1;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (seenM1[i][j] !== W_IN'(matA[i][j]) || seenM2[i][j] !== W_IN'(matB[i][j])) ok = 0;
    checks++;
    if (!ok) begin
      failures++; $display("[TB] FAIL %s operands: got arrays differing from loaded matrices expected exact copy", name);
    end
    checks++;
    if (wrAddrQ.size() !== N) begin
      failures++; $display("[TB] FAIL %s write_count: got %0d expected %0d", name, wrAddrQ.size(), N);
    end
    for (int r = 0; r < N && r < wrAddrQ.size(); r++) begin
      checks++;
      if (wrAddrQ[r] !== (bc + r) % DEPTH) begin
        failures++; $display("[TB] FAIL %s wr_addr[%0d]: got %0d expected %0d", name, r, wrAddrQ[r], (bc + r) % DEPTH);
      end
      wd = wrDataQ[r];
      for (int j = 0; j < N; j++) begin
        int acc = 0;
        for (int k = 0; k < N; k++) acc += matA[r][k] * matB[k][j];
        expEl = W_OUT'(acc);
        checks++;
        if (wd[j*W_OUT +: W_OUT] !== expEl) begin
          failures++; $display("[TB] FAIL %s wr_data[%0d][%0d]: got %0d expected %0d",
                               name, r, j, $signed(wd[j*W_OUT +: W_OUT]), $signed(expEl));
        end
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b1; start = 1'b0; base_a = '0; base_b = '0; base_c = '0;
    rd_data = '0; mm_valid_out = 1'b0; mm_result = '0;
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({busy, done, error, rd_en, wr_en, mm_cen, mm_valid_in} !== 7'b0) begin
      failures++; $display("[TB] FAIL reset_ctl: got %b expected 0000000",
                           {busy, done, error, rd_en, wr_en, mm_cen, mm_valid_in});
    end
    checks++;
    if (mm_matrix_1 !== '0 || mm_matrix_2 !== '0) begin
      failures++; $display("[TB] FAIL reset_operands: got nonzero arrays expected 0");
    end
    start = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_start_ignored: got busy %b expected 0", busy);
    end
    start = 1'b0;
    rstn  = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || rd_en !== 1'b0) begin
      failures++; $display("[TB] FAIL post_reset_idle: got busy %b rd_en %b expected 0 0", busy, rd_en);
    end
  endtask

  task automatic test_identity();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        matA[i][j] = (i == j) ? 1 : 0;
        matB[i][j] = i*8 + j;
      end
    test_matrix_op("identity", 16, 64, 200, 3, -1, -1);
  endtask

  task automatic test_extremes();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin matA[i][j] = -128; matB[i][j] = -128; end
    test_matrix_op("extreme_neg_neg", 0, 8, 16, 0, -1, -1);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) matA[i][j] = 127;
    test_matrix_op("extreme_pos_neg", 300, 400, 500, 5, -1, -1);
  endtask

  task automatic test_random();
    for (int t = 0; t < 3; t++) begin
      int ba, bb, bc, lat, stray;
      randomMatrices();
      ba    = int'($urandom_range(0, DEPTH - 1));
      bb    = (ba + N + int'($urandom_range(0, 500))) % DEPTH;
      bc    = int'($urandom_range(0, DEPTH - 1));
      lat   = int'($urandom_range(0, 12));
      stray = (t == 0) ? 3 : ((t == 1) ? 2*N + 5 + lat : 2*N + 2);
      test_matrix_op($sformatf("random%0d", t), ba, bb, bc, lat, -1, stray);
    end
  endtask

  task automatic test_timeout();
    randomMatrices();
    loadMem(50, 70);
    applyStimulus(50, 70, 90, -1, -1, -1, -1);
    checks++;
    if (errCnt !== 1 || errCyc !== 2*N + 3 + TIMEOUT) begin
      failures++; $display("[TB] FAIL timeout_error: got count %0d at cycle %0d expected 1 at %0d",
                           errCnt, errCyc, 2*N + 3 + TIMEOUT);
    end
    checks++;
    if (doneCnt !== 0) begin
      failures++; $display("[TB] FAIL timeout_done: got %0d expected 0", doneCnt);
    end
    checks++;
    if (wrAddrQ.size() !== 0) begin
      failures++; $display("[TB] FAIL timeout_writes: got %0d expected 0", wrAddrQ.size());
    end
    checks++;
    if (busyCyc !== 2*N + 2 + TIMEOUT) begin
      failures++; $display("[TB] FAIL timeout_busy: got %0d expected %0d", busyCyc, 2*N + 2 + TIMEOUT);
    end
    randomMatrices();
    test_matrix_op("valid_at_timeout", 700, 720, 740, TIMEOUT - 1, -1, -1);
  endtask

  task automatic test_start_while_busy();
    randomMatrices();
    test_matrix_op("start_while_busy", 40, 80, 120, 4, N + 3, -1);
  endtask

  task automatic test_address_wrap();
    randomMatrices();
    test_matrix_op("address_wrap", DEPTH - 4, 500, DEPTH - 3, 1, -1, -1);
  endtask

  task automatic test_reset_in_store();
    bit sawActivity;
    randomMatrices();
    loadMem(100, 300);
    applyStimulus(100, 300, 600, 2, -1, -1, 3);
    checks++;
    if (!rstApplied || wrAddrQ.size() !== 3) begin
      failures++; $display("[TB] FAIL store_reset_point: got applied %0d writes %0d expected 1 3",
                           rstApplied, wrAddrQ.size());
    end
    checks++;
    if (rstCtl !== 7'b0 || rstWr !== '0) begin
      failures++; $display("[TB] FAIL store_reset_outputs: got ctl %b wr_data %h expected zeros", rstCtl, rstWr);
    end
    checks++;
    if (rstMatNz) begin
      failures++; $display("[TB] FAIL store_reset_operands: got nonzero arrays expected 0");
    end
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    sawActivity = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (done || error || busy || wr_en) sawActivity = 1;
    end
    checks++;
    if (sawActivity) begin
      failures++; $display("[TB] FAIL store_reset_quiet: got activity after abort expected none");
    end
    randomMatrices();
    test_matrix_op("after_abort", 100, 300, 600, 2, -1, -1);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "[TB] watchdog abort");
  end

  initial begin
    test_reset();
    test_identity();
    test_extremes();
    test_random();
    test_timeout();
    test_start_while_busy();
    test_address_wrap();
    test_reset_in_store();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mat_mul_ctrl.md
Name: mat_mul_ctrl

Overview:
Sequencer for the 8x8 signed matrix-multiply datapath (mat_mul). On start it loads matrix 1 and matrix 2 from a row-wide local buffer one row per cycle and presents both operands to mat_mul. It then fires one valid_in pulse, waits for valid_out, and writes the N result rows back to the buffer. It reports done or timeout to the host-side control logic.

Parameters:
W_IN, 8, operand element width (signed)
W_OUT, 32, result element width (signed)
N, 8, matrix dimension
AW, 10, buffer row-address width
TIMEOUT, 64, max cycles to wait for mm_valid_out before error

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; accepted only in IDLE
base_a  in  AW  row address of matrix 1 row 0
base_b  in  AW  row address of matrix 2 row 0
base_c  in  AW  row address of result row 0
busy  out  1  high from accepted start until done/error
done  out  1  one-cycle pulse on successful completion
error  out  1  one-cycle pulse on timeout
rd_en  out  1  buffer read strobe
rd_addr  out  AW  buffer read row address
rd_data  in  N*W_IN  row data; valid exactly 1 cycle after rd_en
wr_en  out  1  buffer write strobe
wr_addr  out  AW  buffer write row address
wr_data  out  N*W_OUT  result row; element j at bits [j*W_OUT +: W_OUT]
mm_cen  out  1  clock enable to mat_mul
mm_valid_in  out  1  operand-valid pulse to mat_mul
mm_matrix_1  out  [N][N] x W_IN  operand 1 register array
mm_matrix_2  out  [N][N] x W_IN  operand 2 register array
mm_valid_out  in  1  result valid from mat_mul
mm_result  in  [N][N] x W_OUT  result from mat_mul

Behaviour:
- Reset (rstn low, asynchronous): state IDLE, all strobes/pulses 0, busy 0, counters 0, operand arrays 0, mm_cen 0.
- States: IDLE -> LOAD_A -> LOAD_B -> FIRE -> WAIT -> STORE -> IDLE; WAIT -> IDLE on timeout.
- IDLE: on start, latch base_a/b/c, set busy, go LOAD_A. Start while busy is ignored.
- LOAD_A: rd_en high for N consecutive cycles, rd_addr = base_a + r for r = 0..N-1.
  - Row r is captured into mm_matrix_1[r] one cycle after its read.
  - Element j of a row sits at rd_data[j*W_IN +: W_IN].
  - Reads continue back-to-back into LOAD_B. The last A row is captured during the first LOAD_B cycle.
- LOAD_B: same pattern with base_b into mm_matrix_2. The state lasts N+1 cycles so the final row is captured.
- mm_cen is high from LOAD_A entry until STORE exit; low in IDLE.
- FIRE: mm_valid_in = 1 for exactly one cycle, with both operand arrays stable. The arrays hold until the next start.
- WAIT:
  - The cycle counter starts at 0 on WAIT entry.
  - On mm_valid_out, snapshot mm_result into an internal N x N result register and go STORE.
  - If the counter reaches TIMEOUT-1 with no valid_out: pulse error, clear busy, go IDLE.
  - If valid_out and timeout coincide, valid_out wins.
  - mm_valid_out outside WAIT is ignored.
- STORE: wr_en high for N consecutive cycles, wr_addr = base_c + r, wr_data = snapshot row r.
  - The cycle after the last write: done pulses 1 cycle, busy clears, state goes IDLE.
- Address arithmetic is modulo 2^AW; wrap past the top of the buffer is allowed and is not flagged.
- No arithmetic on data; element widths pass through unchanged.
- Fixed latency from start to done, excluding datapath latency L: 1 (IDLE) + N (LOAD_A) + N+1 (LOAD_B) + 1 (FIRE) + (L+1) (WAIT) + N (STORE).
- Reset mid-operation aborts immediately to IDLE with no done/error pulse. Buffer contents already written are left as is.

Decomposition:
- Shared package mat_mul_pkg holds W_IN, W_OUT, N defaults, the state enum (IDLE, LOAD_A, LOAD_B, FIRE, WAIT, STORE), and a row-pack/unpack function pair.
- Single module, no sub-module. The row counter and timeout counter are internal registers.

Test Plan:
- Identity: A = I, B[i][j] = i*8+j -> C equals B. done asserts exactly 3N+3+L+1 cycles after start. Exactly 8 writes at base_c..base_c+7.
- Extremes: A all -128, B all -128 -> every C element = 131072. A all 127, B all -128 -> every C = -130048. Sign is preserved in wr_data.
- Timeout: bench model never asserts mm_valid_out -> error pulses TIMEOUT cycles after WAIT entry, done never asserts, no wr_en.
- Start while busy: second start pulse mid-LOAD_B -> ignored. A single done, and read/write address sequences unchanged.
- Address wrap: base_c = 2^AW-3 -> writes to 1021, 1022, 1023, 0, 1, 2, 3, 4 (AW = 10).
- Async reset in STORE after 3 writes: assert rstn low -> outputs zero immediately, no done. A subsequent start runs cleanly to done.
